// File: rtl/wb_stage.sv
// Write-back stage: accepts one retired instruction and its result per transfer, commits it to a
// 32-entry register file, and counts retirements. Optional macro WB_BYPASS_EN adds write-through forwarding.
module wb_stage #(
    parameter int BITSIZE  = 32,
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset_i,
    input  logic                EX_WB_give_i,
    output logic                WB_EX_get_o,
    input  logic [31:0]         EX_WB_instruction_i,
    input  logic [BITSIZE-1:0]  EX_WB_d_i,
    input  logic [4:0]          ID_WB_rs1_addr_i,
    input  logic [4:0]          ID_WB_rs2_addr_i,
    output logic [BITSIZE-1:0]  WB_ID_rs1_o,
    output logic [BITSIZE-1:0]  WB_ID_rs2_o,
    output logic [RETIRE_W-1:0] WB_retired_o
);

    typedef enum logic {GET_RESULT, COMMIT} state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t                state_q, state_d;
    logic [31:0]           instr_q, instr_d;
    logic [BITSIZE-1:0]    data_q, data_d;
    logic [RETIRE_W-1:0]   retired_q, retired_d;
    logic [BITSIZE-1:0]    rf_q [32];

    logic [4:0]            rd;
    logic                  commit_wr;
    logic                  unused_instr_bits;

    function automatic logic is_writing(input logic [6:0] opcode);
        case (opcode)
            7'b0110111,
            7'b0010111,
            7'b0010011,
            7'b0110011,
            7'b1101111,
            7'b1100111,
            7'b0000011: is_writing = 1'b1;
            default:    is_writing = 1'b0;
        endcase
    endfunction

    assign rd                = instr_q[11:7];
    assign commit_wr         = (state_q == COMMIT) && is_writing(instr_q[6:0]) && (rd != 5'd0);
    assign unused_instr_bits = ^instr_q[31:12];

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        data_d      = data_q;
        retired_d   = retired_q;
        WB_EX_get_o = 1'b0;
        case (state_q)
            GET_RESULT: begin
                WB_EX_get_o = 1'b1;
                if (EX_WB_give_i) begin
                    instr_d = EX_WB_instruction_i;
                    data_d  = EX_WB_d_i;
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                // Every instruction retires here, writing or not; give is ignored this cycle.
                retired_d = retired_q + 1'b1;
                state_d   = GET_RESULT;
            end
            default: state_d = GET_RESULT;
        endcase
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= GET_RESULT;
            instr_q   <= NOP;
            data_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            data_q    <= data_d;
            retired_q <= retired_d;
        end
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (commit_wr) begin
            rf_q[rd] <= data_q;
        end
    end

    always_comb begin
        WB_ID_rs1_o = (ID_WB_rs1_addr_i == 5'd0) ? '0 : rf_q[ID_WB_rs1_addr_i];
        WB_ID_rs2_o = (ID_WB_rs2_addr_i == 5'd0) ? '0 : rf_q[ID_WB_rs2_addr_i];
`ifdef WB_BYPASS_EN
        // Forward the committing result so decode sees it one cycle earlier.
        if (commit_wr && (ID_WB_rs1_addr_i == rd)) WB_ID_rs1_o = data_q;
        if (commit_wr && (ID_WB_rs2_addr_i == rd)) WB_ID_rs2_o = data_q;
`endif
    end

    assign WB_retired_o = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios with literal expectations plus randomized
// traffic compared every cycle against a transaction-level model of the stage.
`timescale 1ns/1ps
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic        give = 1'b0;
    logic        get;
    logic [31:0] instr = 32'h0;
    logic [31:0] d = 32'h0;
    logic [4:0]  rs1a = 5'd0;
    logic [4:0]  rs2a = 5'd0;
    logic [31:0] rs1, rs2, ret;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;

`ifdef WB_BYPASS_EN
    localparam logic [31:0] X9_IN_COMMIT = 32'h0000_0055;
`else
    localparam logic [31:0] X9_IN_COMMIT = 32'h0000_0000;
`endif

    wb_stage #(.BITSIZE(32), .RETIRE_W(32)) dut (
        .clk                 (clk),
        .reset_i             (reset_i),
        .EX_WB_give_i        (give),
        .WB_EX_get_o         (get),
        .EX_WB_instruction_i (instr),
        .EX_WB_d_i           (d),
        .ID_WB_rs1_addr_i    (rs1a),
        .ID_WB_rs2_addr_i    (rs2a),
        .WB_ID_rs1_o         (rs1),
        .WB_ID_rs2_o         (rs2),
        .WB_retired_o        (ret)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Transaction-level model: a pending transaction (if any) commits on the next edge.
    logic [31:0] m_rf [32];
    logic [31:0] m_ret;
    bit          m_pending;
    logic [31:0] m_instr, m_data;
    bit          m_last_accept;

    function automatic bit writes_rd(input logic [31:0] ins);
        logic [6:0] op;
        op = ins[6:0];
        return (op inside {7'h37, 7'h17, 7'h13, 7'h33, 7'h6F, 7'h67, 7'h03}) && (ins[11:7] != 5'd0);
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
        if (m_pending && writes_rd(m_instr) && (m_instr[11:7] == a)) return m_data;
`endif
        return m_rf[a];
    endfunction

    always @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < 32; i++) m_rf[i] <= 32'h0;
            m_ret         <= 32'h0;
            m_pending     <= 1'b0;
            m_instr       <= 32'h13;
            m_data        <= 32'h0;
            m_last_accept <= 1'b0;
        end else begin
            m_last_accept <= 1'b0;
            if (m_pending) begin
                if (writes_rd(m_instr)) m_rf[m_instr[11:7]] <= m_data;
                m_ret     <= m_ret + 32'd1;
                m_pending <= 1'b0;
            end else if (give) begin
                m_pending     <= 1'b1;
                m_instr       <= instr;
                m_data        <= d;
                m_last_accept <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, got, exp);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("get", {31'b0, get}, {31'b0, !m_pending});
            check("retired", ret, m_ret);
            check("rs1", rs1, exp_read(rs1a));
            check("rs2", rs2, exp_read(rs2a));
        end
    end

    // Entered and left at posedge+1ns; asserts reset between edges.
    task automatic do_reset();
        @(posedge clk);
        #3 reset_i = 1'b1;
        #1 check("rst_get", {31'b0, get}, 32'h1);
        check("rst_ret", ret, 32'h0);
        @(posedge clk);
        #3 reset_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] dd);
        give = 1'b1; instr = ins; d = dd;
        @(posedge clk);
        #1 give = 1'b0;
        check("commit_get_low", {31'b0, get}, 32'h0);
    endtask

    initial begin
        int last_acc;
        bit got_it;
        #3 reset_i = 1'b1;
        #1 cmp_en = 1'b1;
        // Test 1: outputs already reset; all addresses read zero.
        check("t1_get", {31'b0, get}, 32'h1);
        check("t1_ret", ret, 32'h0);
        for (int a = 0; a < 32; a++) begin
            rs1a = 5'(a); rs2a = 5'(31 - a);
            #1 check("t1_rs1", rs1, 32'h0);
            check("t1_rs2", rs2, 32'h0);
        end
        @(posedge clk);
        #3 reset_i = 1'b0;
        @(posedge clk);
        #1;

        // Test 2: LUI x5.
        rs1a = 5'd5;
        send(32'h0000_52B7, 32'h0000_5000);
        @(posedge clk);
        #1 check("t2_x5", rs1, 32'h0000_5000);
        check("t2_ret", ret, 32'h1);
        check("t2_get", {31'b0, get}, 32'h1);

        // Test 3: ADDI x0 is dropped.
        do_reset();
        rs1a = 5'd0;
        send(32'h0010_0013, 32'hDEAD_BEEF);
        @(posedge clk);
        #1 check("t3_x0", rs1, 32'h0);
        check("t3_ret", ret, 32'h1);

        // Test 4: STORE with rd field 7 does not write.
        do_reset();
        rs1a = 5'd7;
        send(32'h0000_03A3, 32'h0000_1234);
        @(posedge clk);
        #1 check("t4_x7", rs1, 32'h0);
        check("t4_ret", ret, 32'h1);

        // Test 5: four back-to-back offers, give held high throughout.
        do_reset();
        last_acc = 0;
        for (int i = 1; i <= 4; i++) begin
            give = 1'b1; instr = (32'(i) << 7) | 32'h13; d = 32'(i);
            got_it = 1'b0;
            for (int w = 0; w < 6 && !got_it; w++) begin
                @(posedge clk);
                #1 if (m_last_accept) got_it = 1'b1;
            end
            check("t5_accepted", {31'b0, got_it}, 32'h1);
            if (i > 1) check("t5_gap", 32'(cyc - last_acc), 32'h2);
            last_acc = cyc;
        end
        give = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 4; i++) begin
            rs1a = 5'(i);
            #1 check("t5_xi", rs1, 32'(i));
        end
        check("t5_ret", ret, 32'h4);

        // Test 6b: clean ADDI x9, read in COMMIT then after.
        do_reset();
        rs2a = 5'd9;
        send(32'h0000_0493, 32'h0000_0055);
        check("t6_x9_commit", rs2, X9_IN_COMMIT);
        @(posedge clk);
        #1 check("t6_x9_after", rs2, 32'h0000_0055);
        check("t6_ret", ret, 32'h1);

        // Test 6a: reset during COMMIT discards the write.
        do_reset();
        send(32'h0000_0493, 32'h0000_0055);
        #1 reset_i = 1'b1;
        #1 check("t6r_x9", rs2, 32'h0);
        check("t6r_ret", ret, 32'h0);
        check("t6r_get", {31'b0, get}, 32'h1);
        @(posedge clk);
        #3 reset_i = 1'b0;
        @(posedge clk);
        #1 check("t6r_x9_late", rs2, 32'h0);
        check("t6r_ret_late", ret, 32'h0);

        // Randomized traffic; a pending offer is held until accepted.
        for (int n = 0; n < 800; n++) begin
            logic [6:0] ops [10];
            ops = '{7'h37, 7'h17, 7'h13, 7'h33, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63, 7'h73};
            if (!(give && !m_last_accept)) begin
                give = ($urandom_range(0, 9) < 7);
                instr = {$urandom_range(0, 32'hFFFFF) , 5'($urandom_range(0, 7)),
                         7'(($urandom_range(0, 19) == 0) ? 7'h7F : ops[$urandom_range(0, 9)])};
                d = $urandom;
            end
            rs1a = 5'($urandom_range(0, 7));
            rs2a = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0) begin
                #2 reset_i = 1'b1;
                #4 reset_i = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        give = 1'b0;
        repeat (3) @(posedge clk);
        #1 cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
